// File: rtl/wps_pkg.sv
// Shared types and default geometry for the WPS frame serializer.
package wps_pkg;

  // Default datapath geometry
  localparam int IN_W_DEF       = 256;
  localparam int OUT_W_DEF      = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  // Derived constants for the default geometry
  localparam int BEATS_PER_WORD = IN_W_DEF / OUT_W_DEF;
  localparam int BYTES_PER_BEAT = OUT_W_DEF / 8;
  localparam int BYTES_PER_WORD = IN_W_DEF / 8;

  // Serializer control states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/wps_word_fifo.sv
// Small synchronous word FIFO. Read data comes straight from the storage
// flops at the read pointer, so the head word is valid whenever empty_o=0.
module wps_word_fifo
  import wps_pkg::*;
#(
  parameter int W     = IN_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; clear empties the FIFO like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Word storage write port.
  // NOTE: storage is deliberately not reset; the pointers alone decide
  // what is valid, and leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wps_frame_serializer.sv
// Buffers wide words from the WPS controller and serializes them into
// narrow beats with start/end-of-frame markers, counting bytes per frame
// and frames per run, then pulses done_out when the run completes.
module wps_frame_serializer
  import wps_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [19:0]      frame_byte_in,
  input  logic [31:0]      frame_num_in,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy_out,
  output logic             done_out,
  output logic             cfg_err_out
);

  localparam int N_BEATS    = IN_W / OUT_W;
  localparam int BEAT_BYTES = OUT_W / 8;
  localparam int WORD_BYTES = IN_W / 8;
  localparam int SLICE_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(N_BEATS - 1);

  state_t              state_q;
  logic [IN_W-1:0]     word_q;
  logic [SLICE_W-1:0]  slice_q;
  logic [19:0]         byte_cnt_q;
  logic [31:0]         frame_cnt_q;
  logic [19:0]         frame_byte_q;
  logic [31:0]         frame_num_q;
  logic                sof_q;
  logic                busy_q;
  logic                done_q;
  logic                cfg_err_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_clr;
  logic [IN_W-1:0]     fifo_rd_data;

  logic                xfer;
  logic                last_slice;
  logic                beat_eof;
  logic                last_frame;
  logic                cfg_ok;

  assign cfg_ok     = (frame_byte_in != '0) &&
                      ((frame_byte_in % 20'(WORD_BYTES)) == '0) &&
                      (frame_num_in != '0);
  assign xfer       = out_valid && out_ready;
  assign last_slice = (slice_q == LAST_SLICE);
  assign beat_eof   = ((byte_cnt_q + 20'(BEAT_BYTES)) == frame_byte_q);
  assign last_frame = beat_eof && ((frame_cnt_q + 32'd1) == frame_num_q);

  // Leftover words from a previous run are flushed by an accepted start.
  assign fifo_clr   = (state_q == ST_IDLE) && start_in && cfg_ok;
  assign fifo_push  = in_valid && in_ready;
  assign in_ready   = rst_n && busy_q && !fifo_full;

  assign out_valid   = (state_q == ST_SHIFT);
  assign out_data    = word_q[OUT_W-1:0];
  assign out_sof     = out_valid && sof_q;
  assign out_eof     = out_valid && beat_eof;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign cfg_err_out = cfg_err_q;

  // Pop a word when LOAD finds data, or when the last slice of a word
  // leaves mid-run so the next word follows without a bubble.
  always_comb begin
    // NOTE: default first so every path assigns fifo_pop and no latch forms.
    fifo_pop = 1'b0;
    case (state_q)
      ST_LOAD:  fifo_pop = !fifo_empty;
      ST_SHIFT: fifo_pop = xfer && last_slice && !last_frame && !fifo_empty;
      default:  fifo_pop = 1'b0;
    endcase
  end

  wps_word_fifo #(
    .W     (IN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .data_i  (in_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Run control FSM: configuration, word loading, beat shifting and counting.
  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      slice_q      <= '0;
      byte_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      frame_byte_q <= '0;
      frame_num_q  <= '0;
      sof_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            if (cfg_ok) begin
              cfg_err_q    <= 1'b0;
              frame_byte_q <= frame_byte_in;
              frame_num_q  <= frame_num_in;
              byte_cnt_q   <= '0;
              frame_cnt_q  <= '0;
              slice_q      <= '0;
              sof_q        <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= ST_LOAD;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (!fifo_empty) begin
            word_q  <= fifo_rd_data;
            slice_q <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (xfer) begin
            if (beat_eof) begin
              byte_cnt_q  <= '0;
              frame_cnt_q <= frame_cnt_q + 32'd1;
              sof_q       <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 20'(BEAT_BYTES);
              sof_q      <= 1'b0;
            end
            if (last_frame) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else if (last_slice) begin
              slice_q <= '0;
              if (!fifo_empty) word_q  <= fifo_rd_data;
              else             state_q <= ST_LOAD;
            end else begin
              slice_q <= slice_q + 1'b1;
              word_q  <= word_q >> OUT_W;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
